idu_pipe: RTL

//  Pipelined, parametrised instruction-decode stage between IFU and EXU.

---
 rtl/idu_pipe.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/idu_pipe.sv
// idu_pipe: RV32I decode stage with the GPR file, a pending-write scoreboard and one output register.
// Define IDU_BYPASS_EN to forward a same-cycle writeback into a waiting source instead of stalling one more cycle.
module idu_pipe #(
  parameter int XLEN           = 32,
  parameter int NR_REG         = 32,
  parameter int REG_ADDR_WIDTH = $clog2(NR_REG)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [XLEN-1:0]           in_inst,
  input  logic [XLEN-1:0]           in_pc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_pc,
  output logic [2:0]                out_inst_type,
  output logic [XLEN-1:0]           out_imm,
  output logic [6:0]                out_opcode,
  output logic [2:0]                out_funct3,
  output logic [6:0]                out_funct7,
  output logic [REG_ADDR_WIDTH-1:0] out_rd,
  output logic                      out_rd_wen,
  output logic [XLEN-1:0]           out_src1,
  output logic [XLEN-1:0]           out_src2,
  input  logic                      wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
  input  logic [XLEN-1:0]           wb_data
);
  localparam logic [2:0] T_N = 3'd0, T_R = 3'd1, T_I = 3'd2, T_S = 3'd3,
                         T_B = 3'd4, T_U = 3'd5, T_J = 3'd6;
  localparam logic [5:0] REG_LIM = 6'(NR_REG);

  logic [6:0]                opcode;
  logic [4:0]                rd_f, rs1_f, rs2_f;
  logic [2:0]                raw_type, dec_type;
  logic                      raw_rs1, raw_rs2, raw_rd, idx_bad;
  logic                      use_rs1, use_rs2, rd_wen;
  logic [XLEN-1:0]           imm;
  logic [REG_ADDR_WIDTH-1:0] rs1, rs2, rd;
  logic [XLEN-1:0]           gpr [NR_REG];
  logic [NR_REG-1:0]         pending;
  logic                      byp1, byp2, hazard, accept, wb_we;
  logic [XLEN-1:0]           src1, src2;

  assign opcode = in_inst[6:0];
  assign rd_f   = in_inst[11:7];
  assign rs1_f  = in_inst[19:15];
  assign rs2_f  = in_inst[24:20];
  assign rs1    = rs1_f[REG_ADDR_WIDTH-1:0];
  assign rs2    = rs2_f[REG_ADDR_WIDTH-1:0];
  assign rd     = rd_f[REG_ADDR_WIDTH-1:0];

  always_comb begin
    raw_type = T_N;
    case (opcode)
      7'b0110111, 7'b0010111:                         raw_type = T_U;
      7'b1101111:                                     raw_type = T_J;
      7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011: raw_type = T_I;
      7'b1100011:                                     raw_type = T_B;
      7'b0100011:                                     raw_type = T_S;
      7'b0110011:                                     raw_type = T_R;
      default:                                        raw_type = T_N;
    endcase
  end

  assign raw_rs1 = (raw_type == T_R) | (raw_type == T_I) | (raw_type == T_S) | (raw_type == T_B);
  assign raw_rs2 = (raw_type == T_R) | (raw_type == T_S) | (raw_type == T_B);
  assign raw_rd  = (raw_type == T_R) | (raw_type == T_I) | (raw_type == T_U) | (raw_type == T_J);

  // Register indices beyond the implemented file (e.g. RV32E) demote the instruction to N.
  assign idx_bad  = (raw_rs1 & ({1'b0, rs1_f} >= REG_LIM)) |
                    (raw_rs2 & ({1'b0, rs2_f} >= REG_LIM)) |
                    (raw_rd  & ({1'b0, rd_f}  >= REG_LIM));
  assign dec_type = idx_bad ? T_N : raw_type;
  assign use_rs1  = raw_rs1 & ~idx_bad;
  assign use_rs2  = raw_rs2 & ~idx_bad;
  assign rd_wen   = raw_rd & ~idx_bad & (rd_f != 5'd0);

  always_comb begin
    imm = '0;
    case (dec_type)
      T_I:     imm = XLEN'($signed(in_inst[31:20]));
      T_S:     imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
      T_B:     imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
      T_U:     imm = XLEN'($signed({in_inst[31:12], 12'b0}));
      T_J:     imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
      default: imm = '0;
    endcase
  end

  assign wb_we = wb_valid & (wb_addr != '0);

`ifdef IDU_BYPASS_EN
  assign byp1 = wb_we & (wb_addr == rs1);
  assign byp2 = wb_we & (wb_addr == rs2);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign src1 = (!use_rs1 || rs1 == '0) ? '0 : (byp1 ? wb_data : gpr[rs1]);
  assign src2 = (!use_rs2 || rs2 == '0) ? '0 : (byp2 ? wb_data : gpr[rs2]);

  // pending[0] is never set because rd_wen excludes x0.
  assign hazard   = (use_rs1 & pending[rs1] & ~byp1) | (use_rs2 & pending[rs2] & ~byp2);
  assign in_ready = (~out_valid | out_ready) & ~hazard;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR_REG; i++) gpr[i] <= '0;
    end else if (wb_we) begin
      gpr[wb_addr] <= wb_data;
    end
  end

  // Set follows clear so an accept targeting the same register keeps it pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      if (wb_we) pending[wb_addr] <= 1'b0;
      if (accept && rd_wen) pending[rd] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_inst_type <= '0;
      out_imm       <= '0;
      out_opcode    <= '0;
      out_funct3    <= '0;
      out_funct7    <= '0;
      out_rd        <= '0;
      out_rd_wen    <= 1'b0;
      out_src1      <= '0;
      out_src2      <= '0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_pc        <= in_pc;
      out_inst_type <= dec_type;
      out_imm       <= imm;
      out_opcode    <= opcode;
      out_funct3    <= in_inst[14:12];
      out_funct7    <= in_inst[31:25];
      out_rd        <= rd;
      out_rd_wen    <= rd_wen;
      out_src1      <= src1;
      out_src2      <= src2;
    end else if (out_ready) begin
      out_valid     <= 1'b0;
    end
  end
endmodule
